pc_sequencer: RTL and testbench

Multicycle-CPU controller that sequences every program-counter update through the 5-input PC source mux. It accepts one update request per instruction from the main control FSM and drives the mux select (`PCSource`), `PCWrite` and `EPCWrite`. On an exception it runs a multi-cycle handler-fetch sequence: save EPC, read the handler address from a fixed memory vector, load PC from `memData`. It sits between the main control unit and the PC/EPC registers, memory address mux and PC source mux.

---
 rtl/pc_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_pc_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// PC-update sequencer for a multicycle CPU: drives the PC source mux select,
// PC/EPC load enables and the exception-vector fetch sequence.
module pc_sequencer #(
    parameter int          MEM_LAT    = 2,
    parameter logic [31:0] VEC_OPCODE = 32'd253,
    parameter logic [31:0] VEC_OVF    = 32'd254,
    parameter logic [31:0] VEC_DIV0   = 32'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [2:0]  kind,
    input  logic        branch_taken,
    input  logic        exc_opcode,
    input  logic        exc_ovf,
    input  logic        exc_div0,
    output logic [2:0]  PCSource,
    output logic        PCWrite,
    output logic        EPCWrite,
    output logic        mem_read,
    output logic [31:0] exc_addr,
    output logic [1:0]  exc_cause,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_UPDATE   = 3'd1,
        S_EXC_EPC  = 3'd2,
        S_EXC_WAIT = 3'd3,
        S_EXC_LOAD = 3'd4
    } state_t;

    // EXC_WAIT exits when the counter reaches zero, so it is loaded with MEM_LAT-2.
    localparam logic [3:0] WAIT_INIT = (MEM_LAT > 1) ? 4'(MEM_LAT - 2) : 4'd0;

    state_t      state_q, state_d;
    logic [2:0]  kind_q, kind_d;
    logic        taken_q, taken_d;
    logic [31:0] vec_q, vec_d;
    logic [1:0]  cause_q, cause_d;
    logic [3:0]  cnt_q, cnt_d;

    logic [2:0]  pc_source_q, pc_source_d;
    logic        pc_write_q, pc_write_d;
    logic        epc_write_q, epc_write_d;
    logic        mem_read_q, mem_read_d;
    logic [31:0] exc_addr_q, exc_addr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        kind_rsvd_s;
    logic        exc_any_s;

    assign kind_rsvd_s = (kind > 3'd4);
    assign exc_any_s   = kind_rsvd_s | exc_opcode | exc_ovf | exc_div0;

    // Next-state, latched request fields and exception cause selection.
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        taken_d = taken_q;
        vec_d   = vec_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    kind_d  = kind;
                    taken_d = branch_taken;
                    if (exc_any_s) begin
                        state_d = S_EXC_EPC;
                        if (kind_rsvd_s || exc_opcode) begin
                            cause_d = 2'b01;
                            vec_d   = VEC_OPCODE;
                        end else if (exc_div0) begin
                            cause_d = 2'b11;
                            vec_d   = VEC_DIV0;
                        end else begin
                            cause_d = 2'b10;
                            vec_d   = VEC_OVF;
                        end
                    end else begin
                        state_d = S_UPDATE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_UPDATE: begin
                state_d = S_IDLE;
            end
            S_EXC_EPC: begin
                if (MEM_LAT > 1) begin
                    state_d = S_EXC_WAIT;
                    cnt_d   = WAIT_INIT;
                end else begin
                    state_d = S_EXC_LOAD;
                end
            end
            S_EXC_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_EXC_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_EXC_LOAD: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are valid in the cycle the state is entered.
    always_comb begin
        pc_source_d = 3'd0;
        pc_write_d  = 1'b0;
        epc_write_d = 1'b0;
        mem_read_d  = 1'b0;
        exc_addr_d  = 32'd0;
        done_d      = 1'b0;
        busy_d      = (state_d != S_IDLE);
        case (state_d)
            S_UPDATE: begin
                done_d = 1'b1;
                case (kind_d)
                    3'd0, 3'd3: begin
                        pc_source_d = 3'b001;
                        pc_write_d  = 1'b1;
                    end
                    3'd1: begin
                        if (taken_d) begin
                            pc_source_d = 3'b010;
                            pc_write_d  = 1'b1;
                        end else begin
                            pc_source_d = 3'b000;
                            pc_write_d  = 1'b0;
                        end
                    end
                    3'd2: begin
                        pc_source_d = 3'b000;
                        pc_write_d  = 1'b1;
                    end
                    3'd4: begin
                        pc_source_d = 3'b100;
                        pc_write_d  = 1'b1;
                    end
                    default: begin
                        pc_source_d = 3'b000;
                        pc_write_d  = 1'b0;
                    end
                endcase
            end
            S_EXC_EPC: begin
                epc_write_d = 1'b1;
                mem_read_d  = 1'b1;
                exc_addr_d  = vec_d;
            end
            S_EXC_WAIT: begin
                mem_read_d = 1'b1;
                exc_addr_d = vec_d;
            end
            S_EXC_LOAD: begin
                pc_source_d = 3'b011;
                pc_write_d  = 1'b1;
                done_d      = 1'b1;
                exc_addr_d  = vec_d;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // State, latched fields and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            kind_q      <= 3'd0;
            taken_q     <= 1'b0;
            vec_q       <= 32'd0;
            cause_q     <= 2'b00;
            cnt_q       <= 4'd0;
            pc_source_q <= 3'd0;
            pc_write_q  <= 1'b0;
            epc_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            exc_addr_q  <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            taken_q     <= taken_d;
            vec_q       <= vec_d;
            cause_q     <= cause_d;
            cnt_q       <= cnt_d;
            pc_source_q <= pc_source_d;
            pc_write_q  <= pc_write_d;
            epc_write_q <= epc_write_d;
            mem_read_q  <= mem_read_d;
            exc_addr_q  <= exc_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign PCSource  = pc_source_q;
    assign PCWrite   = pc_write_q;
    assign EPCWrite  = epc_write_q;
    assign mem_read  = mem_read_q;
    assign exc_addr  = exc_addr_q;
    assign exc_cause = cause_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (MEM_LAT=2 main instance, MEM_LAT=1 second instance).
module tb_pc_sequencer;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        req1 = 1'b0;
    logic [2:0]  kind = 3'd0;
    logic        branch_taken = 1'b0;
    logic        exc_opcode = 1'b0;
    logic        exc_ovf = 1'b0;
    logic        exc_div0 = 1'b0;

    logic [2:0]  PCSource, PCSource1;
    logic        PCWrite, PCWrite1, EPCWrite, EPCWrite1;
    logic        mem_read, mem_read1;
    logic [31:0] exc_addr, exc_addr1;
    logic [1:0]  exc_cause, exc_cause1;
    logic        busy, busy1, done, done1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct packed {
        int          cyc;
        logic [2:0]  src;
        logic        pw;
        logic        ew;
        logic        mr;
        logic [31:0] addr;
        logic [1:0]  cause;
        logic        dn;
    } ev_t;

    ev_t exp_q[$];

    pc_sequencer #(.MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .req(req), .kind(kind), .branch_taken(branch_taken),
        .exc_opcode(exc_opcode), .exc_ovf(exc_ovf), .exc_div0(exc_div0),
        .PCSource(PCSource), .PCWrite(PCWrite), .EPCWrite(EPCWrite), .mem_read(mem_read),
        .exc_addr(exc_addr), .exc_cause(exc_cause), .busy(busy), .done(done)
    );

    pc_sequencer #(.MEM_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .req(req1), .kind(kind), .branch_taken(branch_taken),
        .exc_opcode(exc_opcode), .exc_ovf(exc_ovf), .exc_div0(exc_div0),
        .PCSource(PCSource1), .PCWrite(PCWrite1), .EPCWrite(EPCWrite1), .mem_read(mem_read1),
        .exc_addr(exc_addr1), .exc_cause(exc_cause1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Pops one expected record whenever the DUT shows an EPC save or a completed update.
    always @(negedge clk) begin
        ev_t a;
        if (!reset && (done || EPCWrite)) begin
            a = '{cyc, PCSource, PCWrite, EPCWrite, mem_read, exc_addr, exc_cause, done};
            if (exp_q.size() == 0) begin
                chk("unexpected_event", 80'(a), 80'd0);
            end else begin
                chk("event", 80'(a), 80'(exp_q.pop_front()));
            end
        end
    end

    task automatic clear_inputs();
        req = 1'b0; kind = 3'd0; branch_taken = 1'b0;
        exc_opcode = 1'b0; exc_ovf = 1'b0; exc_div0 = 1'b0;
    endtask

    task automatic run(input string name, input logic [2:0] k, input logic tk,
                       input logic op, input logic ov, input logic dz, input int hold,
                       input logic exc, input logic [2:0] e_src, input logic e_pw,
                       input logic [31:0] e_addr, input logic [1:0] e_cause);
        int n;
        int bc = 0, mc = 0, pwc = 0, ewc = 0;
        @(posedge clk); #1;
        req = 1'b1; kind = k; branch_taken = tk;
        exc_opcode = op; exc_ovf = ov; exc_div0 = dz;
        n = cyc;
        if (exc) begin
            exp_q.push_back('{n + 1, 3'd0, 1'b0, 1'b1, 1'b1, e_addr, e_cause, 1'b0});
            exp_q.push_back('{n + 1 + LAT, 3'd3, 1'b1, 1'b0, 1'b0, e_addr, e_cause, 1'b1});
        end else begin
            exp_q.push_back('{n + 1, e_src, e_pw, 1'b0, 1'b0, 32'd0, e_cause, 1'b1});
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bc += int'(busy); mc += int'(mem_read);
            pwc += int'(PCWrite); ewc += int'(EPCWrite);
            @(posedge clk); #1;
            if (i + 1 >= hold) req = 1'b0;
            kind = k ^ 3'd1; branch_taken = ~tk;
            exc_opcode = 1'b0; exc_ovf = ~ov; exc_div0 = ~dz;
        end
        clear_inputs();
        chk({name, "_busy_cycles"}, 80'(bc), exc ? 80'(1 + LAT) : 80'd1);
        chk({name, "_memread_cycles"}, 80'(mc), exc ? 80'(LAT) : 80'd0);
        chk({name, "_pcwrite_cycles"}, 80'(pwc), 80'(exc | e_pw));
        chk({name, "_epcwrite_cycles"}, 80'(ewc), 80'(exc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pwc;
        int bc1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 80'({PCSource, PCWrite, EPCWrite, mem_read, exc_addr, exc_cause, busy, done}), 80'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        //   name        kind tk op ov dz hold exc src     pw    addr     cause
        run("seq",       3'd0, 0, 0, 0, 0, 1, 0, 3'b001, 1'b1, 32'd0,   2'b00);
        run("jump",      3'd2, 0, 0, 0, 0, 1, 0, 3'b000, 1'b1, 32'd0,   2'b00);
        run("jr",        3'd3, 0, 0, 0, 0, 1, 0, 3'b001, 1'b1, 32'd0,   2'b00);
        run("eret",      3'd4, 0, 0, 0, 0, 1, 0, 3'b100, 1'b1, 32'd0,   2'b00);
        run("br_taken",  3'd1, 1, 0, 0, 0, 1, 0, 3'b010, 1'b1, 32'd0,   2'b00);
        run("br_not",    3'd1, 0, 0, 0, 0, 1, 0, 3'b000, 1'b0, 32'd0,   2'b00);
        run("ovf",       3'd0, 0, 0, 1, 0, 1, 1, 3'b000, 1'b0, 32'd254, 2'b10);
        run("seq_sticky",3'd0, 0, 0, 0, 0, 1, 0, 3'b001, 1'b1, 32'd0,   2'b10);
        run("prio_all",  3'd0, 0, 1, 1, 1, 1, 1, 3'b000, 1'b0, 32'd253, 2'b01);
        run("prio_dz_ov",3'd0, 0, 0, 1, 1, 1, 1, 3'b000, 1'b0, 32'd255, 2'b11);
        run("rsvd_kind", 3'd6, 0, 0, 0, 0, 1, 1, 3'b000, 1'b0, 32'd253, 2'b01);
        run("busy_drop", 3'd0, 0, 0, 0, 1, 4, 1, 3'b000, 1'b0, 32'd255, 2'b11);

        // Reset while the vector read is in flight.
        @(posedge clk); #1;
        req = 1'b1; kind = 3'd2; exc_div0 = 1'b1;
        n = cyc;
        exp_q.push_back('{n + 1, 3'd0, 1'b0, 1'b1, 1'b1, 32'd255, 2'b11, 1'b0});
        @(posedge clk); #1;
        clear_inputs();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_mid_outputs", 80'({PCSource, PCWrite, EPCWrite, mem_read, exc_addr, exc_cause, busy, done}), 80'd0);
        pwc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pwc += int'(PCWrite);
        end
        chk("reset_mid_no_pcwrite", 80'(pwc), 80'd0);
        run("seq_after_rst", 3'd0, 0, 0, 0, 0, 1, 0, 3'b001, 1'b1, 32'd0, 2'b00);

        // MEM_LAT=1 instance: EXC_EPC then EXC_LOAD directly.
        @(posedge clk); #1;
        req1 = 1'b1; exc_ovf = 1'b1;
        @(negedge clk);
        bc1 = int'(busy1);
        @(posedge clk); #1;
        req1 = 1'b0; exc_ovf = 1'b0;
        @(negedge clk);
        bc1 += int'(busy1);
        chk("lat1_epc", 80'({PCSource1, PCWrite1, EPCWrite1, mem_read1, exc_addr1, exc_cause1, done1}),
            80'({3'd0, 1'b0, 1'b1, 1'b1, 32'd254, 2'b10, 1'b0}));
        @(negedge clk);
        bc1 += int'(busy1);
        chk("lat1_load", 80'({PCSource1, PCWrite1, EPCWrite1, mem_read1, exc_addr1, exc_cause1, done1}),
            80'({3'd3, 1'b1, 1'b0, 1'b0, 32'd254, 2'b10, 1'b1}));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bc1 += int'(busy1);
        end
        chk("lat1_busy_cycles", 80'(bc1), 80'd2);

        chk("queue_drained", 80'(exp_q.size()), 80'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
